// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: byte-serial fetch of a 32-bit instruction word into the instruction register.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned pc completes at once with misalign_err and no reads.
module instr_fetch_seq #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        instr8bit_top,
    output logic [3:0]        IRWrite,
    output logic              fetch_en,
    output logic              busy,
    output logic              done
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPTURE, DONE} state_t;
    state_t            state_q;
    logic [1:0]        k_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              skip;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              misalign_q;
    assign skip = pc[1:0] != 2'b00;
    // Only set on the cycle after a misaligned accept, which is the DONE cycle.
    always_ff @(posedge clk)
        misalign_q <= !reset && !flush && fetch_req && skip && (state_q == IDLE || state_q == DONE);
    assign misalign_err = misalign_q;
`else
    assign skip = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            cnt_q      <= 4'd0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            if (flush) state_q <= IDLE;
            else case (state_q)
                IDLE, DONE: if (fetch_req) begin
                    pc_q <= pc;
                    k_q  <= 2'd0;
                    if (skip) state_q <= DONE;
                    else begin
                        state_q    <= REQ;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= pc;
                    end
                end else state_q <= IDLE;
                REQ: begin
                    state_q <= MEM_LAT == 1 ? CAPTURE : WAIT;
                    cnt_q   <= 4'(MEM_LAT - 1);
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= CAPTURE;
                end
                CAPTURE: if (k_q == 2'd3) state_q <= DONE;
                else begin
                    k_q        <= k_q + 2'd1;
                    state_q    <= REQ;
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= pc_q + ADDR_W'(k_q + 2'd1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_addr      = mem_addr_q;
    assign mem_rd        = mem_rd_q && !flush;
    assign instr8bit_top = state_q == CAPTURE ? mem_rdata : 8'h00;
    assign IRWrite       = (state_q == CAPTURE && !flush) ? 4'b1000 >> k_q : 4'b0000;
    assign busy          = state_q == REQ || state_q == WAIT || state_q == CAPTURE;
    assign fetch_en      = !busy;
    assign done          = state_q == DONE;
endmodule
